bcd_counter_2digit: RTL and testbench
=====================================

Name: bcd_counter_2digit

Overview:
- Two-digit BCD up/down counter with a built-in clock prescaler.
- Drives the digit inputs of the downstream two-digit 7-segment decoder: tens digit to seg_data_1, ones digit to seg_data_2.
- Supports run/pause, direction select, synchronous clear and parallel load.
- Programmable wrap value (99 for a 0-99 counter, 59 for seconds display).

Parameters:
CNT_DIV, 12_000_000, clock cycles per count step (12 MHz board clock gives 1 Hz); legal range >= 2.
WRAP_VAL, 99, highest count value; legal range 1..99.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
run  input  1  1 = prescaler advances and counter steps; 0 = pause.
up_down  input  1  1 = count up, 0 = count down; sampled at each step.
clear  input  1  synchronous clear, level-sensitive.
load  input  1  synchronous parallel load, level-sensitive.
load_tens  input  4  BCD tens value for load.
load_ones  input  4  BCD ones value for load.
seg_data_1  output  4  tens digit, BCD 0-9, registered.
seg_data_2  output  4  ones digit, BCD 0-9, registered.
tick  output  1  one-cycle pulse each time the counter steps.
wrap  output  1  one-cycle pulse when the count wraps (WRAP_VAL->0 up, 0->WRAP_VAL down).

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-count):
  - prescaler=0, seg_data_1=0, seg_data_2=0, tick=0, wrap=0.
  - Takes effect immediately, not at the next clock edge.
- Prescaler: counter of width clog2(CNT_DIV), range 0..CNT_DIV-1.
  - Increments each clk while run=1.
  - Holds its value while run=0, so pause/resume does not lose the partial period.
- Step event: on the rising edge where run=1 and prescaler==CNT_DIV-1:
  - prescaler returns to 0 and the digits advance by one.
  - tick is high for exactly the following cycle.
  - Digits are new in that same cycle: zero extra latency between tick and digit change.
  - First step occurs CNT_DIV run-cycles after reset or after clear/load.
- Priority per edge, highest first: clear > load > step > hold.
  - clear=1: digits=00, prescaler=0, tick=0, wrap=0; load and step are ignored.
  - load=1 (clear=0): digits=clamped load value, prescaler=0, tick=0, wrap=0; step is suppressed.
    - Clamping: each digit >9 is clamped to 9 first; the resulting value (10*tens+ones) >WRAP_VAL is clamped to WRAP_VAL.
  - Holding clear or load high keeps the counter frozen with prescaler at 0.
- Up count (up_down=1):
  - ones<9: ones+1.
  - ones==9: ones=0, tens+1.
  - value==WRAP_VAL: digits=00, wrap=1 for one cycle with tick.
- Down count (up_down=0):
  - ones>0: ones-1.
  - ones==0: ones=9, tens-1.
  - value==00: digits=WRAP_VAL digits, wrap=1 for one cycle with tick.
- Invariant: digit outputs are always valid BCD (0-9) and the value never exceeds WRAP_VAL.
  - No internal binary-to-BCD conversion; the digits are counted directly in BCD.
- Direction change between steps: takes effect at the next step with no glitch or skip.
- tick and wrap are registered and deasserted in every cycle without a step.

Test Plan:
1. CNT_DIV=4, WRAP_VAL=99; reset released, run=1, up_down=1 -> tick every 4th cycle; digits 00,01,...,09,10 (carry at 09->10); 00 held during the first 4 cycles.
2. Continue up from load 98 -> steps to 99, then 00 with wrap=1 and tick=1 in the same single cycle; wrap=0 on all other steps.
3. WRAP_VAL=59, up_down=0, load 00 (tens=0, ones=0) -> next step gives 59 with wrap=1; next steps give 58, 57; then load tens=7, ones=12 -> digits clamp to 59.
4. run toggled 1->0 after 2 prescaler cycles, held 10 cycles, then 0->1 -> step occurs exactly 2 run-cycles after resume; no tick while paused; digits unchanged while paused.
5. clear and load both high on the step cycle -> digits 00, tick=0, wrap=0; after release the next step comes CNT_DIV cycles later.
6. rst_n pulsed low mid-period between clock edges with digits at 47 -> outputs read 00, tick=0 immediately, before the next edge; counting restarts from 00 after release.

Source files
------------

// File: rtl/bcd_counter_2digit_if.sv
// Control and display signals of the two-digit BCD counter.
// The master drives the controls; the slave (the counter) drives digits and pulses.
interface bcd_counter_2digit_if;
  logic       run;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic [3:0] seg_data_1;
  logic [3:0] seg_data_2;
  logic       tick;
  logic       wrap;

  modport master (
    output run, up_down, clear, load, load_tens, load_ones,
    input  seg_data_1, seg_data_2, tick, wrap
  );

  modport slave (
    input  run, up_down, clear, load, load_tens, load_ones,
    output seg_data_1, seg_data_2, tick, wrap
  );
endinterface

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with a clock prescaler, programmable wrap value,
// synchronous clear and clamped parallel load; digits feed a 7-segment decoder.
module bcd_counter_2digit #(
  parameter int unsigned CNT_DIV  = 12_000_000,
  parameter int unsigned WRAP_VAL = 99
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_counter_2digit_if.slave   bus
);

  localparam int unsigned PW        = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CNT_DIV - 1);
  localparam logic [3:0] WRAP_TENS  = 4'(WRAP_VAL / 10);
  localparam logic [3:0] WRAP_ONES  = 4'(WRAP_VAL % 10);

  logic [PW-1:0] ps_q, ps_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [3:0]    ld_tens_c, ld_ones_c;
  logic          ld_over;
  logic          at_top, at_zero;

  // Digit clamp first, then value clamp; the value compare is done digit-wise in BCD.
  always_comb begin
    ld_tens_c = (bus.load_tens > 4'd9) ? 4'd9 : bus.load_tens;
    ld_ones_c = (bus.load_ones > 4'd9) ? 4'd9 : bus.load_ones;
    ld_over   = (ld_tens_c > WRAP_TENS) ||
                ((ld_tens_c == WRAP_TENS) && (ld_ones_c > WRAP_ONES));
  end

  assign at_top  = (tens_q == WRAP_TENS) && (ones_q == WRAP_ONES);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    ps_d   = ps_q;
    tens_d = tens_q;
    ones_d = ones_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;

    if (bus.clear) begin
      ps_d   = '0;
      tens_d = '0;
      ones_d = '0;
    end else if (bus.load) begin
      ps_d = '0;
      if (ld_over) begin
        tens_d = WRAP_TENS;
        ones_d = WRAP_ONES;
      end else begin
        tens_d = ld_tens_c;
        ones_d = ld_ones_c;
      end
    end else if (bus.run) begin
      if (ps_q == PS_LAST) begin
        ps_d   = '0;
        tick_d = 1'b1;
        if (bus.up_down) begin
          if (at_top) begin
            tens_d = '0;
            ones_d = '0;
            wrap_d = 1'b1;
          end else if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          if (at_zero) begin
            tens_d = WRAP_TENS;
            ones_d = WRAP_ONES;
            wrap_d = 1'b1;
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      tens_q <= '0;
      ones_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.seg_data_1 = tens_q;
  assign bus.seg_data_2 = ones_q;
  assign bus.tick       = tick_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Bench for bcd_counter_2digit: two instances (wrap 99 and 59) share stimulus and are
// compared every cycle against an integer-valued reference model.
module tb_bcd_counter_2digit;

  localparam int CNT_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_counter_2digit_if if99 ();
  bcd_counter_2digit_if if59 ();

  bcd_counter_2digit #(.CNT_DIV(CNT_DIV), .WRAP_VAL(99)) dut99 (
    .clk(clk), .rst_n(rst_n), .bus(if99)
  );
  bcd_counter_2digit #(.CNT_DIV(CNT_DIV), .WRAP_VAL(59)) dut59 (
    .clk(clk), .rst_n(rst_n), .bus(if59)
  );

  int n_cmp = 0;
  int n_err = 0;

  int wv[2] = '{99, 59};
  int m_val[2];
  int m_pc[2];
  int m_tick[2];
  int m_wrap[2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input bit ud, input bit clr, input bit ld,
                        input int lt, input int lo);
    if99.run = r;  if99.up_down = ud; if99.clear = clr; if99.load = ld;
    if99.load_tens = 4'(lt); if99.load_ones = 4'(lo);
    if59.run = r;  if59.up_down = ud; if59.clear = clr; if59.load = ld;
    if59.load_tens = 4'(lt); if59.load_ones = 4'(lo);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_pc[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference behaviour on one rising edge, using the inputs currently applied.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 0;
      m_wrap[i] = 0;
      if (if99.clear) begin
        m_val[i] = 0;
        m_pc[i]  = 0;
      end else if (if99.load) begin
        m_val[i] = min2(10 * min2(int'(if99.load_tens), 9) + min2(int'(if99.load_ones), 9), wv[i]);
        m_pc[i]  = 0;
      end else if (if99.run) begin
        if (m_pc[i] == CNT_DIV - 1) begin
          m_pc[i]   = 0;
          m_tick[i] = 1;
          if (if99.up_down) begin
            if (m_val[i] == wv[i]) begin m_val[i] = 0; m_wrap[i] = 1; end
            else m_val[i] = m_val[i] + 1;
          end else begin
            if (m_val[i] == 0) begin m_val[i] = wv[i]; m_wrap[i] = 1; end
            else m_val[i] = m_val[i] - 1;
          end
        end else begin
          m_pc[i] = m_pc[i] + 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string phase);
    int g_t, g_o, g_k, g_w;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        g_t = int'(if99.seg_data_1); g_o = int'(if99.seg_data_2);
        g_k = int'(if99.tick);       g_w = int'(if99.wrap);
      end else begin
        g_t = int'(if59.seg_data_1); g_o = int'(if59.seg_data_2);
        g_k = int'(if59.tick);       g_w = int'(if59.wrap);
      end
      check_eq($sformatf("%s w%0d tens", phase, wv[i]), g_t, m_val[i] / 10);
      check_eq($sformatf("%s w%0d ones", phase, wv[i]), g_o, m_val[i] % 10);
      check_eq($sformatf("%s w%0d tick", phase, wv[i]), g_k, m_tick[i]);
      check_eq($sformatf("%s w%0d wrap", phase, wv[i]), g_w, m_wrap[i]);
    end
  endtask

  // Advance one clock edge, update the model, then sample 1 time unit later.
  task automatic step_cycle(input string phase);
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    compare_all(phase);
  endtask

  task automatic run_cycles(input string phase, input int n);
    for (int k = 0; k < n; k++) step_cycle(phase);
  endtask

  initial begin
    set_in(0, 1, 0, 0, 0, 0);
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;

    // Up count from reset through the 09->10 carry
    set_in(1, 1, 0, 0, 0, 0);
    run_cycles("up", 44);

    // Load 98 and cross the top
    set_in(1, 1, 0, 1, 9, 8);
    step_cycle("load98");
    set_in(1, 1, 0, 0, 0, 0);
    run_cycles("upwrap", 12);

    // Down from 00 wraps to the top, then a clamped load
    set_in(1, 0, 0, 1, 0, 0);
    step_cycle("load00");
    set_in(1, 0, 0, 0, 0, 0);
    run_cycles("down", 14);
    set_in(0, 0, 0, 1, 7, 12);
    step_cycle("clampld");
    set_in(0, 0, 0, 0, 0, 0);
    run_cycles("clamphold", 3);

    // Pause mid-period and resume
    set_in(1, 1, 0, 1, 3, 0);
    step_cycle("sync");
    set_in(1, 1, 0, 0, 0, 0);
    run_cycles("prepause", 2);
    set_in(0, 1, 0, 0, 0, 0);
    run_cycles("paused", 10);
    set_in(1, 1, 0, 0, 0, 0);
    run_cycles("resume", 8);

    // clear and load together on the step edge
    for (int k = 0; k < 2 * CNT_DIV && m_pc[0] != CNT_DIV - 1; k++) step_cycle("align");
    check_eq("align_reached", m_pc[0], CNT_DIV - 1);
    set_in(1, 1, 1, 1, 5, 5);
    step_cycle("clrld");
    set_in(1, 1, 0, 0, 0, 0);
    run_cycles("afterclr", 10);

    // Asynchronous reset between edges with 47 displayed
    set_in(0, 1, 0, 1, 4, 7);
    step_cycle("load47");
    set_in(1, 1, 0, 0, 0, 0);
    run_cycles("mid", 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("asyncrst");
    step_cycle("inreset");
    rst_n = 1'b1;
    run_cycles("postrst", 10);

    // Randomized stimulus
    for (int k = 0; k < 3000; k++) begin
      set_in(($urandom % 8) != 0,
             (($urandom % 32) < 20),
             ($urandom % 64) == 0,
             ($urandom % 32) == 0,
             int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
      step_cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
